// File: rtl/ram_p2cc.sv
// 128->512 packing buffer: a distributed-RAM FIFO of narrow words that gathers four at a time into a wide block.
// Optional sticky protocol-error flag enabled by defining PACK_ERR_EN.
module ram_p2cc #(
    parameter int D_WIDTH = 128,
    parameter int A_WIDTH = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_en_w,
    input  logic [D_WIDTH-1:0]     i_data,
    input  logic                   i_en_r,
    output logic [4*D_WIDTH-1:0]   o_data,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [A_WIDTH:0]       o_cnt,
    output logic                   o_err
);

    localparam int DEPTH   = 2 ** A_WIDTH;
    localparam int B_WIDTH = 4 * D_WIDTH;
    localparam logic [A_WIDTH:0] FULL_CNT   = (A_WIDTH + 1)'(DEPTH);
    localparam logic [A_WIDTH:0] GATHER_MIN = (A_WIDTH + 1)'(4);
    localparam logic [A_WIDTH:0] PTR_ONE    = (A_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } state_t;

    state_t               state;
    logic [A_WIDTH:0]     wptr;
    logic [A_WIDTH:0]     rptr;
    logic [A_WIDTH:0]     cnt;
    logic [1:0]           idx;
    logic [B_WIDTH-1:0]   blk;
    logic                 valid;
    logic                 do_write;
    logic [D_WIDTH-1:0]   rd_word;
    logic [D_WIDTH-1:0]   mem [DEPTH];

    // Occupancy comes from registered pointers only; the extra wrap bit separates full from empty.
    assign cnt      = wptr - rptr;
    assign o_cnt    = cnt;
    assign o_full   = (cnt == FULL_CNT);
    assign o_empty  = (cnt == '0);
    assign do_write = i_en_w && !o_full;
    assign rd_word  = mem[rptr[A_WIDTH-1:0]];
    assign o_data   = blk;
    assign o_valid  = valid;

    always_ff @(posedge i_clk) begin
        if (do_write)
            mem[wptr[A_WIDTH-1:0]] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            wptr <= '0;
        else if (do_write)
            wptr <= wptr + PTR_ONE;
    end

    // Gather only starts with four words on hand, so LOAD never has to wait for data.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
            rptr  <= '0;
            idx   <= '0;
            blk   <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!valid && cnt >= GATHER_MIN) begin
                        blk   <= {rd_word, blk[B_WIDTH-1:D_WIDTH]};
                        rptr  <= rptr + PTR_ONE;
                        idx   <= 2'd1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    blk  <= {rd_word, blk[B_WIDTH-1:D_WIDTH]};
                    rptr <= rptr + PTR_ONE;
                    idx  <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        valid <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_en_r) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PACK_ERR_EN
    logic err;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            err <= 1'b0;
        else if ((i_en_w && o_full) || (i_en_r && !valid))
            err <= 1'b1;
    end

    assign o_err = err;
`else
    assign o_err = 1'b0;
`endif

endmodule
